// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes SCLK/WS/SD into the clk domain, deserializes MSB-first
// left/right words and presents each completed stereo frame as a one-cycle pulse.
module i2s_receiver #(
  parameter int DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SCLK,
  input  logic                  WS,
  input  logic                  SD,
  output logic [2*DWIDTH-1:0]   rx_data,
  output logic                  rx_valid,
  output logic                  rx_err
);

  localparam int             CW       = $clog2(DWIDTH + 2);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DWIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DWIDTH - 1);

  typedef enum logic [1:0] {
    ALIGN,
    LEFT,
    RIGHT
  } state_t;

  state_t state;
  state_t state_next;

  logic sclk_s1;
  logic sclk_s2;
  logic sclk_d;
  logic ws_s1;
  logic w;
  logic sd_s1;
  logic sd_s;

  logic              samp;
  logic              word_end;
  logic              wp;
  logic [CW-1:0]     cnt;
  logic [DWIDTH-1:0] left_buf;
  logic [DWIDTH-1:0] right_buf;
  logic [DWIDTH-1:0] word_upd;
  logic              left_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      ws_s1   <= 1'b0;
      w       <= 1'b0;
      sd_s1   <= 1'b0;
      sd_s    <= 1'b0;
    end else begin
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      ws_s1   <= WS;
      w       <= ws_s1;
      sd_s1   <= SD;
      sd_s    <= sd_s1;
    end
  end

  assign samp     = sclk_s2 & ~sclk_d;
  assign word_end = (w != wp);

  // Word buffer with the current bit merged in; the first bit of a word starts from zero
  // so short words come out zero-filled, and bits past DWIDTH match no position.
  always_comb begin
    word_upd = '0;
    if (cnt != '0) begin
      word_upd = wp ? right_buf : left_buf;
    end
    for (int i = 0; i < DWIDTH; i++) begin
      if (cnt == CW'(DWIDTH - 1 - i)) begin
        word_upd[i] = sd_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ALIGN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (samp) begin
      case (state)
        ALIGN:   if (wp && !w) state_next = LEFT;
        LEFT:    if (!wp && w) state_next = RIGHT;
        RIGHT:   if (wp && !w) state_next = LEFT;
        default: state_next = ALIGN;
      endcase
    end
  end

  // The bit sampled at an edge belongs to channel wp; the frame closes on the right word's last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= 1'b0;
      cnt       <= '0;
      left_buf  <= '0;
      right_buf <= '0;
      left_ok   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (samp) begin
        wp <= w;
        if (word_end) begin
          cnt <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
        if (state == LEFT && !wp) begin
          left_buf <= word_upd;
          if (word_end) begin
            left_ok <= (cnt == CNT_LAST);
          end
        end
        if (state == RIGHT && wp) begin
          right_buf <= word_upd;
          if (word_end) begin
            rx_data  <= {left_buf, word_upd};
            rx_valid <= 1'b1;
            rx_err   <= !(left_ok && (cnt == CNT_LAST));
          end
        end
      end
    end
  end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter: DWIDTH, default 8, bits per channel word; rx_data is 2*DWIDTH bits wide.
REQ-002 Port: clk  input  1  system clock; all state is clocked on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: SCLK  input  1  I2S bit clock, asynchronous to clk.
REQ-005 Port: WS  input  1  I2S word select, asynchronous to clk; 0 = left channel, 1 = right channel.
REQ-006 Port: SD  input  1  I2S serial data, asynchronous to clk; MSB first.
REQ-007 Port: rx_data  output  2*DWIDTH  last complete frame; bits [2*DWIDTH-1:DWIDTH] = left word, bits [DWIDTH-1:0] = right word.
REQ-008 Port: rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-009 Port: rx_err  output  1  one-clk pulse, coincident with rx_valid, when either word of the frame had a bit count other than DWIDTH.

Function
REQ-010 SCLK, WS and SD shall each pass through a 2-flop synchronizer on clk; a registered copy of synchronized SCLK shall provide rising-edge detection.
REQ-011 A "sampling edge" is the single clk cycle in which a synchronized SCLK 0->1 transition is detected; synchronized WS (w) and SD are sampled in that cycle.
REQ-012 Register wp holds w from the previous sampling edge; the SD bit sampled at an edge belongs to channel wp (1-bit I2S delay).
REQ-013 Bit counter cnt counts bits of the current word and saturates at DWIDTH+1.
REQ-014 A bit shall be written to word position DWIDTH-1-cnt when cnt < DWIDTH; extra bits (cnt >= DWIDTH) are discarded.
REQ-015 Each word buffer is cleared to zero when its word starts, so short words are zero-filled in the LSBs.
REQ-016 On an edge with w != wp, the current bit is the last bit of its word; cnt resets to 0 for the next edge.
REQ-017 FSM states are ALIGN, LEFT, RIGHT; reset state is ALIGN.
REQ-018 ALIGN: bits are ignored; on an edge with wp=1, w=0 the FSM moves to LEFT.
REQ-019 LEFT: on an edge with wp=0, w=1 the FSM moves to RIGHT.
REQ-020 RIGHT: on an edge with wp=1, w=0, after storing the current bit, the frame is complete and the FSM moves to LEFT.
REQ-021 Frame complete: on the clk cycle after the completing sampling edge, rx_data <= {left, right} and rx_valid = 1 for exactly one cycle.
REQ-022 rx_data shall hold its value between frames.
REQ-023 rx_err shall be 1 with rx_valid if the left or right bit count != DWIDTH; otherwise rx_err = 0.
REQ-024 Latency: rx_valid shall assert no later than 5 clk cycles after the SCLK pin rising edge that carries the right-word LSB.
REQ-025 Timing constraint: SCLK high and low phases shall each be >= 3 clk periods; WS and SD change only on falling SCLK.
REQ-026 There is no backpressure; a frame not consumed is overwritten by the next frame.

Reset
REQ-027 While rst_n = 0: rx_data = 0, rx_valid = 0, rx_err = 0, FSM = ALIGN, cnt = 0, wp = 0, word buffers = 0, synchronizers = 0.
REQ-028 Reset asserted mid-frame shall discard any partial frame; after release, no rx_valid shall occur before a new WS 1->0 alignment edge followed by a full LEFT/RIGHT pair.
REQ-029 A spurious rising edge detected just after reset, because SCLK is high, shall produce no output.

Verification
REQ-030 DWIDTH=8, i2s_transmitter loopback, 64 random 16-bit frames -> each rx_data equals the sent tx_data, rx_err = 0, exactly 64 rx_valid pulses.
REQ-031 Hand-driven frame L=8'hA5, R=8'h3C, 8 bits/word -> rx_data = 16'hA53C, one rx_valid pulse, rx_err = 0.
REQ-032 Words of 6 bits, L=6'b101101, R=6'b111111 -> rx_data = 16'hB4FC, rx_err = 1.
REQ-033 Words of 10 bits, first 8 bits L=8'h81, R=8'h7E, trailing bits = 1 -> rx_data = 16'h817E, rx_err = 1.
REQ-034 Reset released mid right word -> no rx_valid for that frame; the next full frame is received correctly.
REQ-035 Stream starting in a right word (WS=1) -> first rx_valid only after a complete left+right pair.
